// File: rtl/demux3_pkg.sv
// demux3_buf shared definitions: depth, port indices
// and the destination decode used by the top level.
package demux3_pkg;

  localparam int unsigned DEPTH = 2;
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  typedef logic [1:0] port_t;

  localparam port_t PORT0 = 2'd0;
  localparam port_t PORT1 = 2'd1;
  localparam port_t PORT2 = 2'd2;

  function automatic port_t sel_to_port(
    input logic [1:0] sel
  );
    port_t p;
    p = PORT2;
    unique case (1'b1)
      (sel == 2'd0): p = PORT0;
      (sel == 2'd1): p = PORT1;
      default:       p = PORT2;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/demux3_buf_fifo2.sv
// fifo2: two-entry synchronous FIFO with
// registered head, count and wrap-mod-2 pointers.
module fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic [WIDTH-1:0] o_head
);

  import demux3_pkg::*;

  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && (r_cnt != DEPTH_C);
  assign w_pop  = i_pop && (r_cnt != 2'd0);

  // storage, pointers and count; reset clears all
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_count = r_cnt;

  // head word, forced to zero when empty
  always_comb begin
    o_head = '0;
    if (r_cnt != 2'd0) begin
      o_head = r_mem[r_rptr];
    end
  end

endmodule

// File: rtl/demux3_buf.sv
// demux3_buf: routes one input stream to three
// independent 2-deep output FIFOs by in_sel.
module demux3_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             in_ready,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [1:0]       occ0,
  output logic [1:0]       occ1,
  output logic [1:0]       occ2
);

  import demux3_pkg::*;

  port_t            w_tgt;
  logic [1:0]       w_tgt_occ;
  logic             w_acc;
  logic [2:0]       w_push;
  logic [2:0]       w_pop;
  logic [1:0]       w_occ  [0:2];
  logic [WIDTH-1:0] w_head [0:2];

  assign w_tgt = sel_to_port(in_sel);

  // occupancy of the addressed port
  always_comb begin
    w_tgt_occ = w_occ[2];
    unique case (1'b1)
      (w_tgt == PORT0): w_tgt_occ = w_occ[0];
      (w_tgt == PORT1): w_tgt_occ = w_occ[1];
      default:          w_tgt_occ = w_occ[2];
    endcase
  end

  assign in_ready = rst_n && (w_tgt_occ < DEPTH_C);
  assign w_acc    = in_valid && in_ready;

  // one-hot push to the addressed FIFO
  always_comb begin
    w_push = 3'b000;
    unique case (1'b1)
      (w_tgt == PORT0): w_push[0] = w_acc;
      (w_tgt == PORT1): w_push[1] = w_acc;
      default:          w_push[2] = w_acc;
    endcase
  end

  for (genvar k = 0; k < 3; k++) begin : g_port
    assign out_valid[k] = (w_occ[k] != 2'd0);
    assign w_pop[k]     = out_valid[k] && out_ready[k];

    fifo2 #(
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[k]),
      .i_data  (in_data),
      .i_pop   (w_pop[k]),
      .o_count (w_occ[k]),
      .o_head  (w_head[k])
    );
  end

  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign occ0      = w_occ[0];
  assign occ1      = w_occ[1];
  assign occ2      = w_occ[2];

endmodule

// File: tb/tb_demux3_buf.sv
// tb_demux3_buf: directed and random checks of
// demux3_buf against a queue-based reference.
module tb_demux3_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [7:0] out_data0, out_data1, out_data2;
  logic [1:0] occ0, occ1, occ2;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] mq2[$];

  always #5 clk = ~clk;

  demux3_buf #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .occ0      (occ0),
    .occ1      (occ1),
    .occ2      (occ2)
  );

  function automatic int msize(input int k);
    if (k == 0) return mq0.size();
    if (k == 1) return mq1.size();
    return mq2.size();
  endfunction

  function automatic logic [7:0] mhead(input int k);
    if (msize(k) == 0) return 8'h00;
    if (k == 0) return mq0[0];
    if (k == 1) return mq1[0];
    return mq2[0];
  endfunction

  function automatic int mport(input logic [1:0] s);
    return (s == 2'd3) ? 2 : int'(s);
  endfunction

  function automatic logic mready();
    return rst_n && (msize(mport(in_sel)) < 2);
  endfunction

  // advance one clock; model follows the rules
  task automatic tick();
    logic       acc;
    int         tp;
    logic [7:0] d;
    logic [2:0] pop;
    acc = in_valid && mready();
    tp  = mport(in_sel);
    d   = in_data;
    for (int k = 0; k < 3; k++)
      pop[k] = out_ready[k] && (msize(k) > 0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq0.delete(); mq1.delete(); mq2.delete();
    end else begin
      if (pop[0]) void'(mq0.pop_front());
      if (pop[1]) void'(mq1.pop_front());
      if (pop[2]) void'(mq2.pop_front());
      if (acc) begin
        if (tp == 0) mq0.push_back(d);
        else if (tp == 1) mq1.push_back(d);
        else mq2.push_back(d);
      end
    end
  endtask

  task automatic push(input logic [1:0] s,
                      input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 3'b111;
    repeat (3) tick();
    out_ready = 3'b000;
    vecs++;
    if ({occ0, occ1, occ2} !== 6'd0) begin
      errs++;
      $display("FAIL drain occ=%h/%h/%h want 0",
               occ0, occ1, occ2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 8'hFF;
    out_ready = 3'b000;
    repeat (2) tick();
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_in_ready got %b want 0",
               in_ready);
    end
    vecs++;
    if (out_valid !== 3'b000) begin
      errs++;
      $display("FAIL rst_out_valid got %b want 000",
               out_valid);
    end
    vecs++;
    if ({occ0, occ1, occ2} !== 6'd0) begin
      errs++;
      $display("FAIL rst_occ got %h/%h/%h want 0",
               occ0, occ1, occ2);
    end
    vecs++;
    if ({out_data0, out_data1, out_data2} !== 24'd0)
    begin
      errs++;
      $display("FAIL rst_data got %h/%h/%h want 0",
               out_data0, out_data1, out_data2);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_routing();
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    vecs++;
    if ({out_data0, out_data1, out_data2}
        !== 24'h112233) begin
      errs++;
      $display("FAIL route_data got %h/%h/%h want 11/22/33",
               out_data0, out_data1, out_data2);
    end
    vecs++;
    if (occ2 !== 2'd2 || out_valid !== 3'b111) begin
      errs++;
      $display("FAIL route_occ occ2=%0d ov=%b want 2 111",
               occ2, out_valid);
    end
    drain();
  endtask

  task automatic test_full();
    push(2'd1, 8'hA1);
    push(2'd1, 8'hA2);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA3;
    #1;
    vecs++;
    if (in_ready !== 1'b0 || occ1 !== 2'd2) begin
      errs++;
      $display("FAIL full_block rdy=%b occ1=%0d want 0 2",
               in_ready, occ1);
    end
    tick();
    in_sel = 2'd0; in_data = 8'hB0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL full_other_rdy got %b want 1",
               in_ready);
    end
    tick();
    in_valid = 1'b0;
    vecs++;
    if (occ0 !== 2'd1 || occ1 !== 2'd2 ||
        out_data1 !== 8'hA1 || out_data0 !== 8'hB0) begin
      errs++;
      $display("FAIL full_state occ0=%0d occ1=%0d d0=%h d1=%h want 1 2 B0 A1",
               occ0, occ1, out_data0, out_data1);
    end
    drain();
  endtask

  task automatic test_order_wrap();
    int nxt = 1;
    int exp = 1;
    int cyc = 0;
    in_sel = 2'd2;
    while (exp <= 8 && cyc < 100) begin
      in_valid     = (nxt <= 8);
      in_data      = 8'(nxt);
      out_ready[2] = cyc[0];
      #1;
      if (out_valid[2] && out_ready[2]) begin
        vecs++;
        if (out_data2 !== 8'(exp)) begin
          errs++;
          $display("FAIL order got %h want %h",
                   out_data2, 8'(exp));
        end
        exp++;
      end
      if (occ2 > 2'd2) begin
        errs++;
        $display("FAIL order_occ got %0d want <=2", occ2);
      end
      if (in_valid && in_ready) nxt++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 3'b000;
    vecs++;
    if (exp != 9) begin
      errs++;
      $display("FAIL order_timeout got %0d words want 8",
               exp - 1);
    end
  endtask

  task automatic test_simul();
    push(2'd0, 8'h55);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h66;
    out_ready = 3'b001;
    tick();
    in_valid = 1'b0;
    out_ready = 3'b000;
    vecs++;
    if (occ0 !== 2'd1 || out_data0 !== 8'h66) begin
      errs++;
      $display("FAIL simul occ0=%0d d0=%h want 1 66",
               occ0, out_data0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    push(2'd0, 8'hC0);
    push(2'd1, 8'hC1);
    push(2'd2, 8'hC2);
    push(2'd2, 8'hC3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vecs++;
    if ({occ0, occ1, occ2} !== 6'd0 ||
        out_valid !== 3'b000) begin
      errs++;
      $display("FAIL rmid occ=%h/%h/%h ov=%b want 0",
               occ0, occ1, occ2, out_valid);
    end
    out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (out_valid !== 3'b000) begin
        errs++;
        $display("FAIL rmid_ghost ov=%b want 000",
                 out_valid);
      end
    end
    out_ready = 3'b000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      in_valid  = $urandom_range(0, 1);
      in_sel    = 2'($urandom);
      in_data   = 8'($urandom);
      out_ready = 3'($urandom);
      #1;
      vecs++;
      if (in_ready !== mready()) begin
        errs++;
        $display("FAIL rnd_rdy @%0d got %b want %b",
                 i, in_ready, mready());
      end
      vecs++;
      if (out_valid !== {msize(2) > 0, msize(1) > 0,
                         msize(0) > 0}) begin
        errs++;
        $display("FAIL rnd_ov @%0d got %b", i, out_valid);
      end
      vecs++;
      if ({occ0, occ1, occ2} !== {2'(msize(0)),
          2'(msize(1)), 2'(msize(2))}) begin
        errs++;
        $display("FAIL rnd_occ @%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 i, occ0, occ1, occ2,
                 msize(0), msize(1), msize(2));
      end
      vecs++;
      if ({out_data0, out_data1, out_data2} !==
          {mhead(0), mhead(1), mhead(2)}) begin
        errs++;
        $display("FAIL rnd_data @%0d got %h/%h/%h want %h/%h/%h",
                 i, out_data0, out_data1, out_data2,
                 mhead(0), mhead(1), mhead(2));
      end
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = 8'h00;
    out_ready = 3'b000;
    #2;
    test_reset();
    test_routing();
    test_full();
    test_order_wrap();
    drain();
    test_simul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/demux3_buf.md
DEMUX3_BUF -- requirements
Module: demux3_buf

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data port.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  upstream word offered.
REQ-005 in_data  input  WIDTH  upstream word.
REQ-006 in_sel  input  2  destination code: 0 -> port 0, 1 -> port 1, 2 -> port 2, 3 -> port 2.
REQ-007 in_ready  output  1  word accepted this cycle when in_valid is also high.
REQ-008 out_valid  output  3  bit k high: port k holds a word.
REQ-009 out_ready  input  3  bit k high: port k consumer takes its word this cycle.
REQ-010 out_data0, out_data1, out_data2  output  WIDTH each  head word of port 0/1/2.
REQ-011 occ0, occ1, occ2  output  2 each  current entry count of port 0/1/2 (0..2).

Function
REQ-012 Each port SHALL own an independent 2-entry FIFO; words reach a port strictly in acceptance order.
REQ-013 The target port SHALL be decoded from in_sel per REQ-006; codes 2 and 3 are equivalent.
REQ-014 in_ready SHALL be combinational: high iff the target port's occupancy < 2; no pass-through when full (a same-cycle pop does not raise in_ready).
REQ-015 Push SHALL occur on an edge where in_valid && in_ready; in_data is written to the target FIFO tail.
REQ-016 Upstream SHALL hold in_data and in_sel stable while in_valid is high and in_ready is low; the block does not latch an unaccepted word.
REQ-017 out_valid[k] SHALL equal (occ_k != 0); out_data_k SHALL present the head entry, and 0 when empty.
REQ-018 Pop of port k SHALL occur on an edge where out_valid[k] && out_ready[k]; out_ready[k] while empty has no effect.
REQ-019 Latency: a word pushed at edge n SHALL appear on its port at cycle n+1 (registered, no combinational in-to-out path).
REQ-020 Simultaneous push and pop on the same port (occupancy 1) SHALL leave occupancy at 1, with the new word next in line.
REQ-021 Push to one port and pops on other ports in the same cycle SHALL all take effect independently.
REQ-022 Occupancy SHALL never exceed 2 nor go below 0; read/write pointers wrap modulo 2.
REQ-023 Stalling one port SHALL NOT block words targeted at other ports (no head-of-line blocking).

Reset
REQ-024 With rst_n low at an edge: all occupancies 0, pointers 0, storage cleared, out_valid = 0, out_data0..2 = 0, occ0..2 = 0.
REQ-025 in_ready SHALL be low while rst_n is low.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words; no word accepted before reset appears after it.

Structure
REQ-027 Shared package demux3_pkg SHALL hold: FIFO depth constant (2), port-index constants, and the sel-to-port decode function.
REQ-028 One sub-module fifo2 (2-entry synchronous FIFO, WIDTH-parameterised, push/pop/count/head) SHALL be instantiated three times.
REQ-029 Decode and in_ready logic SHALL reside in demux3_buf top level.

Verification
REQ-030 Reset: hold rst_n low 2 cycles with in_valid=1 -> in_ready=0, out_valid=000, all occ=0, all out_data=0.
REQ-031 Routing: push 0x11 sel=0, 0x22 sel=1, 0x33 sel=2, 0x44 sel=3, out_ready=000 -> out_data0=0x11, out_data1=0x22, out_data2=0x33, occ2=2, out_valid=111.
REQ-032 Full/backpressure: push 0xA1,0xA2 to port 1, out_ready=000, offer 0xA3 sel=1 -> in_ready=0, occ1=2; offer 0xB0 sel=0 -> accepted, occ0=1.
REQ-033 Order and wrap: stream 0x01..0x08 to port 2 with out_ready[2] toggling every cycle -> port 2 emits 0x01..0x08 in order, occ2 never >2.
REQ-034 Simultaneous: port 0 holds 0x55, same cycle push 0x66 sel=0 and out_ready[0]=1 -> next cycle occ0=1, out_data0=0x66.
REQ-035 Reset mid-stream: ports hold words, pull rst_n low 1 cycle -> occ all 0; after release no prior word appears on any port.
